uart_rx_core: RTL
=================

Name: uart_rx_core

Overview:
- Serial receive front end that sits directly upstream of the AHBUart register/FIFO logic.
- Synchronises the `rx` pin, detects start bits, samples 8N1 frames at mid-bit using a programmable clocks-per-bit divisor, and presents each byte through a one-entry valid/ready holding register.
- Reports framing and overrun errors.
- Drives the `rts` flow-control output.

Parameters:
- RATE_W, 16, width of the clocks-per-bit divisor input.
- SYNC_STAGES, 2, flops in the rx synchroniser (minimum 2).

Ports:
- clk  input  1  system clock; all state on the rising edge.
- nReset  input  1  reset; asynchronous assert, active-high (1 = in reset), synchronous deassert handled by the integrator.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rate  input  RATE_W  clocks per bit, programmed by the baud register.
- data  output  8  received byte, LSB first on the line.
- valid  output  1  data holds an unconsumed byte.
- ready  input  1  consumer accepts data when valid&&ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: frame completed while the buffer was full and not being read.
- parity_err  output  1  one-cycle pulse (see Optional Feature); constant 0 when the feature is absent.
- rts  output  1  request-to-send; high when the buffer is empty or being read this cycle (equals !valid || ready).
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset values:
  - data=0, valid=0, frame_err=0, overrun=0, parity_err=0, busy=0, rts=1.
  - FSM=IDLE.
  - Synchroniser flops=1; counters=0.
- rx_s is the output of the SYNC_STAGES-deep synchroniser. All decisions use rx_s only.
- Effective divisor: r = max(rate,4). It is latched into r_q on IDLE->START. Changes to `rate` mid-frame are ignored until the next frame.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rx_s==0, go to START and clear cnt.
  - START: cnt increments each cycle. At cnt==(r_q>>1)-1, sample rx_s.
    - If 1: false start, return to IDLE with no error.
    - If 0: go to DATA and clear cnt and the bit index.
  - DATA: at cnt==r_q-1, shift rx_s into bit[idx] and clear cnt. After idx==7 is sampled, go to STOP (or to PARITY when the feature is enabled).
  - STOP: at cnt==r_q-1, sample rx_s.
    - If 1: complete the frame and go to IDLE.
    - If 0: complete the frame, pulse frame_err, go to WAIT_HIGH.
  - WAIT_HIGH (break/line-low): stay until rx_s==1, then go to IDLE. No new start detection while in this state.
- Frame completion: registered on the stop-sample edge.
  - If valid==0 or ready==1: data<=shift reg, valid<=1.
  - Otherwise: data is unchanged, the new byte is dropped, and overrun pulses.
  - A byte with a framing error is still delivered.
- Consume: valid&&ready with no completion in the same cycle sets valid<=0.
  - Completion and ready in the same cycle: the old byte is consumed, the new byte is loaded, valid stays 1, no overrun.
- Latency: valid rises SYNC_STAGES + (r_q>>1) + 9*r_q cycles (±1) after rx falls at the pin.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is discarded and no error pulses are produced.
- cnt width is RATE_W. No wrap occurs because cnt is cleared at r_q-1.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state sits between DATA and STOP and samples at cnt==r_q-1.
  - parity_err pulses on the stop-sample edge if XOR(data bits, parity bit) != 0. The byte is still delivered.
  - Latency grows by r_q.
- Undefined:
  - No PARITY state; frame is 8N1.
  - parity_err is tied 0.

Test Plan:
1. Reset values: nReset=1 with rx toggling -> outputs at reset values, rts=1. After release with rx idle -> busy=0 for 100 cycles.
2. Single byte: rate=16, send 0xA5 8N1, ready=0 -> valid rises 154±1 cycles after the start edge, data=0xA5. Holding ready=0 keeps valid=1 and data stable. Pulsing ready=1 for one cycle -> valid=0.
3. False start and clamp: rate=16, rx low for 5 cycles then high -> FSM returns to IDLE, no valid, no frame_err. rate=2 -> behaves as rate=4 (0x3C received correctly).
4. Overrun and simultaneous events: ready=0, send 0x11 then 0x22 -> data=0x11, one overrun pulse. Repeat with ready=1 in the exact completion cycle of 0x22 -> data=0x22, valid=1, no overrun.
5. Framing error and break: send 0x7E with stop bit low, then hold rx low for 40 bit times -> data=0x7E, frame_err pulses once, busy=1 until rx returns high, then a following 0x55 is received correctly.
6. Mid-frame reset and rate change: assert nReset during bit 4 of 0xC3 -> valid stays 0, no error pulses. Change rate from 16 to 8 mid-frame -> current frame is still decoded at 16, the next frame at 8. With UART_RX_PARITY_EN: send 0x01 with parity bit 0 -> parity_err pulses once, data=0x01.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: serial receive front end for the AHBUart block.
// Synchronises rx, detects start bits, samples frames at mid-bit using a
// programmable clocks-per-bit divisor, and presents each byte through a
// one-entry valid/ready holding register with framing/overrun reporting.
// Optional build macro: UART_RX_PARITY_EN (8E1 frames with a parity check;
// when undefined, frames are 8N1 and parity_err is tied low).
module uart_rx_core #(
  parameter int RATE_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              rx,
  input  logic [RATE_W-1:0] rate,
  output logic [7:0]        data,
  output logic              valid,
  input  logic              ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err,
  output logic              rts,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [RATE_W-1:0]      cnt_q, cnt_d;
  logic [RATE_W-1:0]      r_q, r_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   done;

  logic              rx_s;
  logic [RATE_W-1:0] r_eff, full_m1, half_m1;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  // Divisors below 4 would leave no room for a mid-bit sample point.
  assign r_eff   = (rate < RATE_W'(4)) ? RATE_W'(4) : rate;
  assign full_m1 = r_q - 1'b1;
  assign half_m1 = (r_q >> 1) - 1'b1;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
`endif

  // Frame FSM: start validation, bit sampling, stop check, break wait.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], rx};
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    done    = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: if (!rx_s) begin
        state_d = START;
        cnt_d   = '0;
        r_d     = r_eff;
      end
      START: begin
        if (cnt_q == half_m1) begin
          if (rx_s) state_d = IDLE;
          else begin
            state_d = DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end else cnt_d = cnt_q + 1'b1;
      end
      DATA: begin
        if (cnt_q == full_m1) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = '0;
          idx_d          = idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (idx_q == 3'd7) state_d = PARITY;
`else
          if (idx_q == 3'd7) state_d = STOP;
`endif
        end else cnt_d = cnt_q + 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == full_m1) begin
          par_d   = rx_s;
          cnt_d   = '0;
          state_d = STOP;
        end else cnt_d = cnt_q + 1'b1;
      end
`endif
      STOP: begin
        if (cnt_q == full_m1) begin
          done  = 1'b1;
          cnt_d = '0;
          if (rx_s) state_d = IDLE;
          else begin
            // Line still low: flag it and wait out the break before re-arming.
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else cnt_d = cnt_q + 1'b1;
      end
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: all data bits plus the parity bit must XOR to zero.
  always_comb perr_d = done & (^{shift_q, par_q});
`endif

  // Holding register: a consume and a completion in one cycle swap bytes.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && ready) valid_d = 1'b0;
    if (done) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else ovr_d = 1'b1;
    end
  end

  // State registers; reset drops any partial frame without error pulses.
  always_ff @(posedge clk or posedge nReset) begin
    if (nReset) begin
      state_q <= IDLE;
      sync_q  <= '1;
      cnt_q   <= '0;
      r_q     <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif
  assign rts  = !valid_q || ready;
  assign busy = (state_q != IDLE);

endmodule
